load_store_unit: RTL and testbench

Sequential load/store unit between the execute stage and the word-wide data memory. It turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word accesses on the memory port.
- Sub-word stores use read-modify-write, because the memory only writes whole words.
- Sub-word loads return the addressed lane, sign- or zero-extended.
- A start/busy/done handshake lets the core stall for the duration of an access.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_if.sv | 26 ++
 rtl/lsu_byte_lane.sv | 37 +++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states and access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // funct3[1:0] alone selects the width; the unused codes 011/110/111 fall into word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and word-memory signals of the load/store unit.
interface lsu_if #(parameter int ADDR_W = 32);
  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic              busy;
  logic              done;
  logic [31:0]       load_data;
  logic              misaligned;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata;
  logic              mem_rw;
  logic [31:0]       mem_rdata;

  modport master (
    output start, is_store, funct3, addr, store_data, mem_rdata,
    input  busy, done, load_data, misaligned, mem_address, mem_wdata, mem_rw
  );

  modport slave (
    input  start, is_store, funct3, addr, store_data, mem_rdata,
    output busy, done, load_data, misaligned, mem_address, mem_wdata, mem_rw
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends a load value and merges a sub-word store
// into the word read from memory.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = word_i[{off_i, 3'b000} +: 8];
    half_v  = word_i[{off_i[1], 4'b0000} +: 16];
    load_o  = word_i;
    merge_o = sdata_i;
    case (f3_size(funct3_i))
      SZ_B: begin
        load_o  = funct3_i[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        merge_o = word_i;
        merge_o[{off_i, 3'b000} +: 8] = sdata_i[7:0];
      end
      SZ_H: begin
        load_o  = funct3_i[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        merge_o = word_i;
        merge_o[{off_i[1], 4'b0000} +: 16] = sdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential RV32I load/store unit over a word-wide memory (read-modify-write for SB/SH).
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses trap instead of aligning.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic clock,
  input  logic reset,
  lsu_if.slave bus
);

  lsu_state_t        state_q;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q;
  logic              st_q;
  logic [31:0]       sdata_q;
  logic              busy_q, done_q, mis_q, mem_rw_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [31:0]       mem_wdata_q, load_data_q;
  logic [31:0]       load_w, merge_w;
  lsu_size_t         req_sz;
  logic              trap_hit;

  assign req_sz = f3_size(bus.funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = ((req_sz == SZ_H) && bus.addr[0]) ||
                    ((req_sz == SZ_W) && (bus.addr[1:0] != 2'b00));
`else
  assign trap_hit = 1'b0;
`endif

  // Without the trap, offending low address bits are simply dropped.
  always_comb begin
    case (req_sz)
      SZ_B:    off_d = bus.addr[1:0];
      SZ_H:    off_d = {bus.addr[1], 1'b0};
      default: off_d = 2'b00;
    endcase
  end

  lsu_byte_lane u_lane (
    .word_i   (bus.mem_rdata),
    .funct3_i (f3_q),
    .off_i    (off_q),
    .sdata_i  (sdata_q),
    .load_o   (load_w),
    .merge_o  (merge_w)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
      st_q          <= 1'b0;
      sdata_q       <= 32'h0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mis_q         <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= 32'h0;
      load_data_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            off_q         <= off_d;
            f3_q          <= bus.funct3;
            st_q          <= bus.is_store;
            sdata_q       <= bus.store_data;
            mem_address_q <= {bus.addr[ADDR_W-1:2], 2'b00};
            busy_q        <= 1'b1;
            if (trap_hit) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else if (bus.is_store && (req_sz == SZ_W)) begin
              state_q     <= WR;
              mem_wdata_q <= bus.store_data;
              mem_rw_q    <= 1'b1;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          if (st_q) begin
            state_q     <= WR;
            mem_wdata_q <= merge_w;
            mem_rw_q    <= 1'b1;
          end else begin
            state_q     <= DONE;
            load_data_q <= load_w;
            done_q      <= 1'b1;
          end
        end
        WR: begin
          state_q  <= DONE;
          mem_rw_q <= 1'b0;
          done_q   <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          mis_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.misaligned  = mis_q;
  assign bus.mem_rw      = mem_rw_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.load_data   = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random accesses
// compared against a byte-addressed reference memory.
module tb_load_store_unit;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;

  lsu_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [64];
  logic [7:0]  refmem [256];
  logic [31:0] exp_ld;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) bus.mem_rdata <= mem[bus.mem_address[7:2]];
  always @(posedge clock) if (bus.mem_rw) mem[bus.mem_address[7:2]] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a - (a % 4);
    return {refmem[b+3], refmem[b+2], refmem[b+1], refmem[b]};
  endfunction

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    int sz, lat, cyc, nwr, ea;
    logic trap;
    logic [31:0] v, exp_wd;
    sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (int'(a) % sz) != 0;
`endif
    ea  = int'(a) - (int'(a) % sz);
    lat = trap ? 1 : (!st || sz == 4) ? 2 : 3;
    if (st && !trap)
      for (int i = 0; i < sz; i++) refmem[ea+i] = d[8*i +: 8];
    exp_wd = ref_word(ea);
    if (!st && !trap) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = refmem[ea+i];
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      exp_ld = v;
    end

    @(negedge clock);
    bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.store_data = d;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.addr = $urandom; bus.store_data = $urandom;
    bus.funct3 = 3'($urandom_range(0, 7)); bus.is_store = ~st;
    cyc = 1; nwr = 0;
    while (!bus.done && cyc < 12) begin
      check("busy", 32'(bus.busy), 32'd1);
      if (bus.mem_rw) begin
        nwr++;
        check("wr_addr", bus.mem_address, 32'(ea - (ea % 4)));
        check("wr_data", bus.mem_wdata, exp_wd);
      end
      @(posedge clock); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("misaligned", 32'(bus.misaligned), 32'(trap));
    check("rw_at_done", 32'(bus.mem_rw), 32'd0);
    check("writes", 32'(nwr), 32'((st && !trap) ? 1 : 0));
    check("load_data", bus.load_data, exp_ld);
    check("mem_word", mem[ea/4], exp_wd);
    @(posedge clock); #1;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int dones;
    logic st;
    logic [2:0] f3;
    n_chk = 0; n_err = 0; exp_ld = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      for (int j = 0; j < 4; j++) refmem[4*i+j] = mem[i][8*j +: 8];
    end
    reset = 1'b1;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b0; bus.addr = 32'h0;
    bus.store_data = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rw", 32'(bus.mem_rw), 32'd0);
    check("rst_addr", bus.mem_address, 32'h0);
    check("rst_ld", bus.load_data, 32'h0);
    @(negedge clock) reset = 1'b0;

    do_op(1'b1, 3'b010, 32'h10, 32'h8899AABB);
    check("sw_word", mem[4], 32'h8899AABB);
    do_op(1'b0, 3'b000, 32'h11, 32'h0);
    check("lb", bus.load_data, 32'hFFFFFFAA);
    do_op(1'b0, 3'b100, 32'h11, 32'h0);
    check("lbu", bus.load_data, 32'h000000AA);
    do_op(1'b1, 3'b000, 32'h12, 32'h12345655);
    do_op(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_after_sb", bus.load_data, 32'h8855AABB);
    do_op(1'b0, 3'b001, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh_trap_ld", bus.load_data, 32'h8855AABB);
`else
    check("lh_align_ld", bus.load_data, 32'hFFFF8855);
`endif

    // Reset during the write cycle of SH 0xBEEF to 0x14.
    @(negedge clock);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b001; bus.addr = 32'h14;
    bus.store_data = 32'h0000BEEF;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    check("sh_wr_cycle", 32'(bus.mem_rw), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_rw", 32'(bus.mem_rw), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_addr", bus.mem_address, 32'h0);
    check("abort_wdata", bus.mem_wdata, 32'h0);
    check("abort_ld", bus.load_data, 32'h0);
    @(posedge clock); #1;
    check("abort_mem", mem[5], ref_word(32'h14));
    exp_ld = 32'h0;
    @(negedge clock) reset = 1'b0;

    // Start pulsed while busy must be ignored.
    @(negedge clock);
    bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h10;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(negedge clock);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h20;
    bus.store_data = 32'hDEADBEEF;
    @(posedge clock); #1;
    bus.start = 1'b0;
    dones = 32'(bus.done);
    check("busy_ld", bus.load_data, ref_word(32'h10));
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
      check("busy_no_wr", 32'(bus.mem_rw), 32'd0);
    end
    check("busy_dones", 32'(dones), 32'd1);
    check("busy_mem20", mem[8], ref_word(32'h20));
    exp_ld = ref_word(32'h10);

    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_op(st, f3, 32'($urandom_range(0, 255)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
